// File: rtl/instr_reorder_buf_pkg.sv
// -----------------------------------------------------------------------------
// instr_reorder_buf_pkg
// Purpose : Shared types and helpers for the instruction reorder buffer. This
//           is the subset of the ariane_pkg scoreboard entry that the buffer
//           looks at, plus the is_mem_fu / regs_conflict helpers.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package instr_reorder_buf_pkg;

    typedef enum logic [2:0] {
        FU_NONE      = 3'd0,
        FU_LOAD      = 3'd1,
        FU_STORE     = 3'd2,
        FU_ALU       = 3'd3,
        FU_CTRL_FLOW = 3'd4,
        FU_MULT      = 3'd5,
        FU_CSR       = 3'd6,
        FU_FENCE     = 3'd7
    } fu_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_rs1_fpr;
        logic        is_rs2_fpr;
        logic        is_rd_fpr;
    } scoreboard_entry_t;

    function automatic logic is_mem_fu(input fu_t fu);
        return (fu == FU_LOAD) || (fu == FU_STORE);
    endfunction

    // CSR accesses and fences must keep their program position
    function automatic logic is_serial_fu(input fu_t fu);
        return (fu == FU_CSR) || (fu == FU_FENCE);
    endfunction

    // Same architectural register: index and register file must agree.
    // x0 is hard-wired, so it never creates a hazard; f0 is a real register.
    function automatic logic reg_match(input logic [4:0] idx_a, input logic fp_a,
                                       input logic [4:0] idx_b, input logic fp_b);
        return (idx_a == idx_b) && (fp_a == fp_b) && (fp_a || (idx_a != 5'd0));
    endfunction

    // True when younger entry sbe_a depends on older entry sbe_b (RAW, WAW or WAR)
    function automatic logic regs_conflict(input scoreboard_entry_t sbe_a,
                                           input scoreboard_entry_t sbe_b);
        logic raw;
        logic waw;
        logic war;
        raw = reg_match(sbe_a.rs1, sbe_a.is_rs1_fpr, sbe_b.rd, sbe_b.is_rd_fpr)
            | reg_match(sbe_a.rs2, sbe_a.is_rs2_fpr, sbe_b.rd, sbe_b.is_rd_fpr);
        waw = reg_match(sbe_a.rd, sbe_a.is_rd_fpr, sbe_b.rd, sbe_b.is_rd_fpr);
        war = reg_match(sbe_a.rd, sbe_a.is_rd_fpr, sbe_b.rs1, sbe_b.is_rs1_fpr)
            | reg_match(sbe_a.rd, sbe_a.is_rd_fpr, sbe_b.rs2, sbe_b.is_rs2_fpr);
        return raw | waw | war;
    endfunction

endpackage

// File: rtl/instr_reorder_buf_sel.sv
// -----------------------------------------------------------------------------
// instr_reorder_sel
// Purpose : Picks which buffered slot is presented to the scoreboard. Slot 0
//           (oldest) unless it is a memory op stalled on the LSU, in which case
//           the lowest independent non-memory slot inside the window is chosen.
// Ports   : entries_i    - buffer contents, slot 0 oldest
//           count_i      - number of valid slots
//           bypass_en_i  - reordering enable
//           lsu_ready_i  - LSU can accept a memory op
//           sel_o        - selected slot index
// -----------------------------------------------------------------------------
module instr_reorder_sel
    import instr_reorder_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WINDOW = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1),
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  scoreboard_entry_t entries_i [DEPTH],
    input  logic [CNT_W-1:0]  count_i,
    input  logic              bypass_en_i,
    input  logic              lsu_ready_i,
    output logic [IDX_W-1:0]  sel_o
);

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] unused_fields;

    assign cand[0] = 1'b0;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fields
        assign unused_fields[gi] = ^{entries_i[gi].pc, entries_i[gi].op};
    end

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_cand
        localparam bit IN_WINDOW = (gi < WINDOW);
        logic dep_any;

        // Must not depend on any older entry it would overtake
        always_comb begin
            dep_any = 1'b0;
            for (int j = 0; j < gi; j++) begin
                dep_any = dep_any | regs_conflict(entries_i[gi], entries_i[j]);
            end
        end

        assign cand[gi] = IN_WINDOW && (CNT_W'(gi) < count_i)
                        && !is_mem_fu(entries_i[gi].fu)
                        && !is_serial_fu(entries_i[gi].fu)
                        && !dep_any;
    end

    always_comb begin
        sel_o = '0;
        if (bypass_en_i && !lsu_ready_i && (count_i != '0) && is_mem_fu(entries_i[0].fu)) begin
            // Descending scan so the lowest (oldest) candidate wins
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (cand[k]) begin
                    sel_o = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/instr_reorder_buf.sv
// -----------------------------------------------------------------------------
// instr_reorder_buf
// Purpose : DEPTH-entry compacting reorder buffer between issue_read and the
//           scoreboard. Empty buffer is a zero-latency pass-through; a memory op
//           stalled on the LSU may be overtaken by an independent younger
//           non-memory op. Control-flow instructions are never buffered.
// Ports   : clk_i, rst_ni                   - clock, async active-low reset
//           flush_i                         - discard all buffered entries
//           bypass_en_i                     - reordering enable (0 = FIFO)
//           issue_entry_i/_valid_i          - upstream instruction
//           is_ctrl_flow_i                  - upstream instr is branch/jump
//           issue_instr_ack_o               - upstream instr consumed
//           issue_entry_o/_valid_o          - instruction to scoreboard
//           is_ctrl_flow_o                  - presented instr is control flow
//           issue_instr_ack_i               - scoreboard accepted it
//           lsu_ready_i                     - LSU can take a memory op
//           occupancy_o                     - number of buffered entries
// -----------------------------------------------------------------------------
module instr_reorder_buf
    import instr_reorder_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WINDOW = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              bypass_en_i,
    input  scoreboard_entry_t issue_entry_i,
    input  logic              issue_entry_valid_i,
    input  logic              is_ctrl_flow_i,
    output logic              issue_instr_ack_o,
    output scoreboard_entry_t issue_entry_o,
    output logic              issue_entry_valid_o,
    output logic              is_ctrl_flow_o,
    input  logic              issue_instr_ack_i,
    input  logic              lsu_ready_i,
    output logic [CNT_W-1:0]  occupancy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    scoreboard_entry_t mem_reg  [DEPTH];
    scoreboard_entry_t mem_next [DEPTH];
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  count_after_pop;
    logic [IDX_W-1:0]  sel_idx;
    logic              empty;
    logic              pop;
    logic              push;

    instr_reorder_sel #(
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_sel (
        .entries_i   (mem_reg),
        .count_i     (count_reg),
        .bypass_en_i (bypass_en_i),
        .lsu_ready_i (lsu_ready_i),
        .sel_o       (sel_idx)
    );

    always_comb begin
        issue_entry_o       = issue_entry_i;
        issue_entry_valid_o = issue_entry_valid_i;
        is_ctrl_flow_o      = is_ctrl_flow_i;
        issue_instr_ack_o   = 1'b0;
        push                = 1'b0;
        empty               = (count_reg == '0);
        pop                 = !empty && issue_instr_ack_i;

        if (empty) begin
            // Pass-through; anything non-ctrl-flow the scoreboard refuses is captured
            issue_instr_ack_o = issue_instr_ack_i | (issue_entry_valid_i & !is_ctrl_flow_i);
            push              = issue_entry_valid_i & !issue_instr_ack_i & !is_ctrl_flow_i;
        end else begin
            issue_entry_o       = mem_reg[sel_idx];
            issue_entry_valid_o = 1'b1;
            is_ctrl_flow_o      = 1'b0;
            // Ctrl flow waits for drain so it never passes a buffered entry
            issue_instr_ack_o   = issue_entry_valid_i & !is_ctrl_flow_i
                                & ((count_reg < CNT_W'(DEPTH)) | pop);
            push                = issue_instr_ack_o;
        end

        count_after_pop = count_reg - CNT_W'(pop);
        count_next      = flush_i ? '0 : (count_after_pop + CNT_W'(push));
    end

    // Per slot: close the gap left by the popped entry, then append at the tail
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        scoreboard_entry_t shifted;
        if (gi < DEPTH - 1) begin : g_shift
            assign shifted = (pop && (IDX_W'(gi) >= sel_idx)) ? mem_reg[gi+1] : mem_reg[gi];
        end else begin : g_last
            assign shifted = mem_reg[gi];
        end
        assign mem_next[gi] = (push && !flush_i && (count_after_pop == CNT_W'(gi)))
                            ? issue_entry_i : shifted;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= mem_next[i];
            end
        end
    end

    assign occupancy_o = count_reg;

endmodule
